// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard beside decode. It selects the operand-forwarding source for
// each decode operand and raises a stall on load-use, long-latency RAW, WAW and
// long-unit capacity hazards. It tracks outstanding multi-cycle writebacks in a
// per-register busy map, with an outstanding-op counter, a saturating stall-cycle
// counter and a sticky writeback-error flag.
module hazard_scoreboard_unit #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int MAX_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_FWD + 2)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [NUM_SRC*5-1:0]           id_rs_addr,
  input  logic [NUM_SRC-1:0]             id_rs_used,
  input  logic                           id_we,
  input  logic [4:0]                     id_rd,
  input  logic                           id_long,
  input  logic                           flush,
  input  logic [NUM_FWD-1:0]             fwd_we,
  input  logic [NUM_FWD*5-1:0]           fwd_rd_addr,
  input  logic [NUM_FWD-1:0]             fwd_ready,
  input  logic                           long_done,
  input  logic [4:0]                     long_done_rd,
  output logic [NUM_SRC*SEL_W-1:0]       fwd_sel,
  output logic                           stall,
  output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt,
  output logic [31:0]                    stall_cycles,
  output logic                           sb_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [31:0]              r_busy;
  logic [CNT_W-1:0]         r_out_cnt;
  logic [31:0]              r_stall_cycles;
  logic                     r_sb_err;

  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                     w_ld_stall;
  logic                     w_raw_stall;
  logic                     w_waw_stall;
  logic                     w_cap_stall;
  logic                     w_stall;
  logic                     w_acc;

  // Per-source forward select (youngest stage wins, then the long-unit bypass),
  // plus the load-use and long-result RAW stall terms.
  always_comb begin : comb_fwd
    logic [4:0]  w_addr;
    logic        w_live;
    logic        w_hit;
    logic        w_hit_rdy;
    logic        w_bypass;
    int unsigned w_k;
    w_fwd_sel   = '0;
    w_ld_stall  = 1'b0;
    w_raw_stall = 1'b0;
    w_addr      = '0;
    w_live      = 1'b0;
    w_hit       = 1'b0;
    w_hit_rdy   = 1'b0;
    w_bypass    = 1'b0;
    w_k         = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_addr    = id_rs_addr[5*i +: 5];
      w_live    = id_valid && id_rs_used[i] && (w_addr != 5'd0);
      w_hit     = 1'b0;
      w_hit_rdy = 1'b0;
      w_k       = 0;
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (!w_hit && fwd_we[k] && (fwd_rd_addr[5*k +: 5] == w_addr)) begin
          w_hit     = 1'b1;
          w_hit_rdy = fwd_ready[k];
          w_k       = k;
        end
      end
      w_bypass = long_done && (long_done_rd == w_addr);
      if (w_live) begin
        if (w_hit) begin
          w_fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(w_k + 1);
          if (!w_hit_rdy) w_ld_stall = 1'b1;
        end else if (w_bypass) begin
          w_fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(NUM_FWD + 1);
        end else if (r_busy[w_addr]) begin
          w_raw_stall = 1'b1;
        end
      end
    end
  end

  // WAW and capacity stall terms, overall stall and long-op acceptance.
  always_comb begin
    w_waw_stall = id_valid && id_we && (id_rd != 5'd0) && r_busy[id_rd] &&
                  !(long_done && (long_done_rd == id_rd));
    w_cap_stall = id_valid && id_long && (r_out_cnt == CNT_W'(MAX_OUT)) && !long_done;
    w_stall     = !flush && (w_ld_stall || w_raw_stall || w_waw_stall || w_cap_stall);
    w_acc       = id_valid && id_long && id_we && (id_rd != 5'd0) && !w_stall && !flush;
  end

  // Busy map: writeback clears, acceptance sets; the later set wins on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (long_done && (long_done_rd != 5'd0)) r_busy[long_done_rd] <= 1'b0;
      if (w_acc) r_busy[id_rd] <= 1'b1;
    end
  end

  // Outstanding long-op counter, bounded at MAX_OUT and at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else begin
      case ({w_acc, long_done})
        2'b10:   if (r_out_cnt != CNT_W'(MAX_OUT)) r_out_cnt <= r_out_cnt + 1'b1;
        2'b01:   if (r_out_cnt != '0) r_out_cnt <= r_out_cnt - 1'b1;
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // Sticky error on a writeback nothing was waiting for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else if (long_done &&
                 (((long_done_rd != 5'd0) && !r_busy[long_done_rd]) || (r_out_cnt == '0))) begin
      r_sb_err <= 1'b1;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign fwd_sel      = w_fwd_sel;
  assign stall        = w_stall;
  assign out_cnt      = r_out_cnt;
  assign stall_cycles = r_stall_cycles;
  assign sb_err       = r_sb_err;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed hazard scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_hazard_scoreboard_unit;

  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int MAX_OUT = 4;
  localparam int SEL_W   = $clog2(NUM_FWD + 2);
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic                     clk;
  logic                     rst;
  logic                     id_valid;
  logic [NUM_SRC*5-1:0]     id_rs_addr;
  logic [NUM_SRC-1:0]       id_rs_used;
  logic                     id_we;
  logic [4:0]               id_rd;
  logic                     id_long;
  logic                     flush;
  logic [NUM_FWD-1:0]       fwd_we;
  logic [NUM_FWD*5-1:0]     fwd_rd_addr;
  logic [NUM_FWD-1:0]       fwd_ready;
  logic                     long_done;
  logic [4:0]               long_done_rd;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
  logic [CW-1:0]            out_cnt;
  logic [31:0]              stall_cycles;
  logic                     sb_err;

  hazard_scoreboard_unit #(
    .NUM_SRC(NUM_SRC),
    .NUM_FWD(NUM_FWD),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_we(id_we), .id_rd(id_rd), .id_long(id_long), .flush(flush),
    .fwd_we(fwd_we), .fwd_rd_addr(fwd_rd_addr), .fwd_ready(fwd_ready),
    .long_done(long_done), .long_done_rd(long_done_rd),
    .fwd_sel(fwd_sel), .stall(stall), .out_cnt(out_cnt),
    .stall_cycles(stall_cycles), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_busy [32];
  int          m_cnt;
  longint      m_stc;
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs_addr = '0; id_rs_used = '0; id_we = 0; id_rd = '0;
    id_long = 0; flush = 0; fwd_we = '0; fwd_rd_addr = '0; fwd_ready = '1;
    long_done = 0; long_done_rd = '0;
  endtask

  task automatic set_src(input int i, input int a);
    id_rs_used[i] = 1'b1;
    id_rs_addr[5*i +: 5] = 5'(a);
  endtask

  task automatic set_stage(input int k, input int a, input bit rdy);
    fwd_we[k] = 1'b1;
    fwd_rd_addr[5*k +: 5] = 5'(a);
    fwd_ready[k] = rdy;
  endtask

  // Forward source seen by operand i: youngest writing stage, then long-unit bypass.
  function automatic int ref_sel(input int i);
    int a;
    a = int'(id_rs_addr[5*i +: 5]);
    if (!id_valid || !id_rs_used[i] || a == 0) return 0;
    for (int k = 0; k < NUM_FWD; k++)
      if (fwd_we[k] && int'(fwd_rd_addr[5*k +: 5]) == a) return k + 1;
    if (long_done && int'(long_done_rd) == a) return NUM_FWD + 1;
    return 0;
  endfunction

  function automatic bit ref_stall();
    bit st;
    int a, s;
    st = 0;
    if (flush) return 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = int'(id_rs_addr[5*i +: 5]);
      if (id_valid && id_rs_used[i] && a != 0) begin
        s = ref_sel(i);
        if (s >= 1 && s <= NUM_FWD && !fwd_ready[s-1]) st = 1;
        if (s == 0 && m_busy[a]) st = 1;
      end
    end
    if (id_valid && id_we && id_rd != 0 && m_busy[id_rd] && !(long_done && long_done_rd == id_rd)) st = 1;
    if (id_valid && id_long && m_cnt == MAX_OUT && !long_done) st = 1;
    return st;
  endfunction

  function automatic void model_reset();
    foreach (m_busy[r]) m_busy[r] = 0;
    m_cnt = 0; m_stc = 0; m_err = 0;
  endfunction

  // Compare all outputs with the model for the current inputs, then let one clock pass.
  task automatic step();
    bit st, acc;
    #1;
    st = ref_stall();
    for (int i = 0; i < NUM_SRC; i++)
      check($sformatf("fwd_sel[%0d]", i), 64'(fwd_sel[SEL_W*i +: SEL_W]), 64'(ref_sel(i)));
    check("stall", 64'(stall), 64'(st));
    check("out_cnt", 64'(out_cnt), 64'(m_cnt));
    check("stall_cycles", 64'(stall_cycles), 64'(m_stc));
    check("sb_err", 64'(sb_err), 64'(m_err));
    acc = id_valid && id_long && id_we && id_rd != 0 && !st && !flush;
    if (long_done) begin
      if ((long_done_rd != 0 && !m_busy[long_done_rd]) || m_cnt == 0) m_err = 1;
      if (long_done_rd != 0) m_busy[long_done_rd] = 0;
    end
    if (acc) m_busy[id_rd] = 1;
    if (acc && !long_done && m_cnt < MAX_OUT) m_cnt++;
    else if (long_done && !acc && m_cnt > 0) m_cnt--;
    if (st && m_stc < 64'hFFFF_FFFF) m_stc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #1;
    model_reset();
    check("rst_fwd_sel", 64'(fwd_sel), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_out_cnt", 64'(out_cnt), 64'd0);
    check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    check("rst_sb_err", 64'(sb_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue_long(input int rd);
    idle();
    id_valid = 1; id_long = 1; id_we = 1; id_rd = 5'(rd);
  endtask

  initial begin
    int q[$];
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Youngest-stage priority; x0 never forwards
    idle(); id_valid = 1; set_src(0, 5); set_stage(0, 5, 1); set_stage(1, 5, 1);
    #1; check("fwd_youngest", 64'(fwd_sel[SEL_W-1:0]), 64'd1);
    check("fwd_youngest_stall", 64'(stall), 64'd0);
    step();
    idle(); id_valid = 1; set_src(0, 0); set_stage(0, 5, 1); set_stage(1, 5, 1);
    #1; check("fwd_x0", 64'(fwd_sel[SEL_W-1:0]), 64'd0);
    step();

    // Load-use then release from the older stage
    idle(); id_valid = 1; set_src(1, 7); set_stage(0, 7, 0);
    #1; check("loaduse_stall", 64'(stall), 64'd1);
    check("loaduse_sel", 64'(fwd_sel[SEL_W +: SEL_W]), 64'd1);
    step();
    idle(); id_valid = 1; set_src(1, 7); set_stage(1, 7, 1);
    #1; check("loaduse_release_stall", 64'(stall), 64'd0);
    check("loaduse_release_sel", 64'(fwd_sel[SEL_W +: SEL_W]), 64'd2);
    check("loaduse_stall_cycles", 64'(stall_cycles), 64'd1);
    step();

    // Long op RAW with same-cycle writeback bypass
    issue_long(9); step();
    check("long_out_cnt", 64'(out_cnt), 64'd1);
    idle(); id_valid = 1; set_src(0, 9);
    #1; check("raw_stall", 64'(stall), 64'd1);
    step(); step();
    long_done = 1; long_done_rd = 9;
    #1; check("raw_bypass_stall", 64'(stall), 64'd0);
    check("raw_bypass_sel", 64'(fwd_sel[SEL_W-1:0]), 64'(NUM_FWD + 1));
    step();
    idle(); step();
    check("raw_done_out_cnt", 64'(out_cnt), 64'd0);

    // Capacity limit, relieved by a same-cycle writeback
    for (int r = 1; r <= 4; r++) begin issue_long(r); step(); end
    check("cap_full", 64'(out_cnt), 64'(MAX_OUT));
    issue_long(11);
    #1; check("cap_stall", 64'(stall), 64'd1);
    step();
    issue_long(11); long_done = 1; long_done_rd = 1;
    #1; check("cap_relief_stall", 64'(stall), 64'd0);
    step();
    check("cap_hold", 64'(out_cnt), 64'(MAX_OUT));
    foreach (q[j]) q.delete(j);
    q = '{2, 3, 4, 11};
    foreach (q[j]) begin idle(); long_done = 1; long_done_rd = 5'(q[j]); step(); end
    check("cap_drained", 64'(out_cnt), 64'd0);

    // WAW against a busy register, and flush suppression
    issue_long(10); step();
    idle(); id_valid = 1; id_we = 1; id_rd = 10;
    #1; check("waw_stall", 64'(stall), 64'd1);
    step();
    idle(); id_valid = 1; id_we = 1; id_rd = 10; flush = 1;
    #1; check("waw_flush_stall", 64'(stall), 64'd0);
    step();
    idle(); id_valid = 1; id_we = 1; id_rd = 10;
    #1; check("waw_busy_kept", 64'(stall), 64'd1);
    step();
    idle(); long_done = 1; long_done_rd = 10; step();

    // Randomized traffic; writebacks only target registers the model holds busy
    for (int n = 0; n < 3000; n++) begin
      idle();
      id_valid   = $urandom_range(0, 3) != 0;
      id_rs_used = NUM_SRC'($urandom);
      for (int i = 0; i < NUM_SRC; i++) id_rs_addr[5*i +: 5] = 5'($urandom_range(0, 7));
      id_we   = $urandom_range(0, 1) != 0;
      id_rd   = 5'($urandom_range(0, 7));
      id_long = $urandom_range(0, 3) == 0;
      flush   = $urandom_range(0, 7) == 0;
      for (int k = 0; k < NUM_FWD; k++) begin
        fwd_we[k] = $urandom_range(0, 1) != 0;
        fwd_rd_addr[5*k +: 5] = 5'($urandom_range(0, 7));
        fwd_ready[k] = $urandom_range(0, 3) != 0;
      end
      q.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        long_done = 1;
        long_done_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
      end
      step();
    end

    // Drain, then unexpected writeback sets the sticky error
    for (int r = 1; r < 32; r++) if (m_busy[r]) begin idle(); long_done = 1; long_done_rd = 5'(r); step(); end
    idle(); long_done = 1; long_done_rd = 12; step();
    check("sb_err_set", 64'(sb_err), 64'd1);
    idle(); step(); step();
    check("sb_err_sticky", 64'(sb_err), 64'd1);

    // Mid-run reset clears everything without waiting for a clock edge
    issue_long(6); step();
    idle(); id_valid = 1; set_src(0, 6); step();
    do_reset();
    idle(); long_done = 1; long_done_rd = 6; step();
    check("post_rst_err", 64'(sb_err), 64'd1);
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline forwarding logic.
- Produces per-source operand-forward selects across NUM_FWD in-flight stages (youngest-first priority), plus a stall for load-use and long-latency (mul/div) hazards.
- Holds a register scoreboard for outstanding multi-cycle results, an outstanding-op counter, a saturating stall-cycle counter and a sticky error flag.
- Sits beside the decode stage; its outputs drive the EX operand muxes and the pipeline stall control.

Parameters:
NUM_SRC, 2, number of source operands checked per instruction
NUM_FWD, 2, forwarding stages; index 0 = youngest (EX), NUM_FWD-1 = oldest
MAX_OUT, 4, maximum outstanding long-latency ops (>=1)
SEL_W, $clog2(NUM_FWD+2), width of one forward-select field (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  decode instruction valid
id_rs_addr  in  NUM_SRC*5  source register addresses, src i at [5i+4:5i]
id_rs_used  in  NUM_SRC  source i actually read
id_we  in  1  decode instruction writes a register
id_rd  in  5  decode destination register
id_long  in  1  decode instruction is multi-cycle (mul/div)
flush  in  1  kill the decode instruction this cycle
fwd_we  in  NUM_FWD  stage k will write a register
fwd_rd_addr  in  NUM_FWD*5  stage k destination
fwd_ready  in  NUM_FWD  stage k result is available now (0 = load in flight)
long_done  in  1  long unit writes back this cycle
long_done_rd  in  5  long unit writeback register
fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = regfile, k+1 = stage k, NUM_FWD+1 = long-unit result
stall  out  1  hold decode
out_cnt  out  $clog2(MAX_OUT+1)  outstanding long ops
stall_cycles  out  32  saturating count of cycles with stall=1
sb_err  out  1  sticky: long_done to a non-busy register

Behaviour:
- Reset (async, rst=1): busy[31:0]=0, out_cnt=0, stall_cycles=0, sb_err=0. Combinational outputs then give fwd_sel=0 and stall=0.
- Source i is "live" when id_valid & id_rs_used[i] & addr!=0. Non-live sources: fwd_sel=0 and no stall contribution.
- fwd_sel for a live source, all combinational:
  - Pick the lowest k with fwd_we[k] & fwd_rd_addr[k]==addr; output k+1.
  - If no stage matches and long_done & long_done_rd==addr, output NUM_FWD+1.
  - Otherwise output 0.
- Stall terms (OR-ed), all suppressed when flush=1:
  - (a) Load-use: a live source's chosen stage k has fwd_ready[k]=0.
  - (b) RAW on long result: busy[addr]=1 for a live source, with no stage match and no same-cycle long_done bypass.
  - (c) WAW: id_valid & id_we & id_rd!=0 & busy[id_rd] & !(long_done & long_done_rd==id_rd).
  - (d) Capacity: id_valid & id_long & out_cnt==MAX_OUT & !long_done.
- Accept: acc = id_valid & id_long & id_we & id_rd!=0 & !stall & !flush.
- Scoreboard update, next clock edge:
  - long_done clears busy[long_done_rd].
  - acc sets busy[id_rd].
  - Same register set and cleared in one cycle: set wins. This is legal because the WAW term lets it through only in that case.
  - long_done_rd==0 is ignored.
- out_cnt next = out_cnt + acc - long_done. Both in one cycle: unchanged. Never exceeds MAX_OUT; decrement at 0 does not underflow and sets sb_err.
- sb_err: set when long_done occurs with busy[long_done_rd]=0 (rd!=0) or out_cnt==0. Cleared only by rst.
- stall_cycles increments by 1 each cycle stall=1 and holds at 32'hFFFF_FFFF.
- flush does not clear busy or out_cnt: issued long ops always write back.
- Reset asserted mid-operation: all state clears immediately; any long_done arriving after reset sets sb_err.

Test Plan:
- x5 written in stage0 and stage1 (both ready), decode reads rs1=x5 -> fwd_sel[src0]=1 (youngest), stall=0; rs1=x0 under the same stimulus -> fwd_sel=0.
- Load to x7 in stage0 with fwd_ready[0]=0, decode rs2=x7 -> stall=1, fwd_sel[src1]=1; next cycle load in stage1 with ready=1, stage0 empty -> stall=0, fwd_sel[src1]=2, stall_cycles=1.
- Long op to x9 accepted -> busy[9]=1, out_cnt=1. Dependent read of x9 -> stall until long_done with rd=9; in that cycle stall=0 and fwd_sel=NUM_FWD+1; next cycle busy[9]=0, out_cnt=0.
- MAX_OUT=4: issue 4 long ops to x1..x4; fifth long op -> stall=1; same cycle long_done rd=1 -> fifth accepted, out_cnt stays 4.
- WAW: x10 busy, short op id_rd=10 -> stall=1. Same with flush=1 -> stall=0, busy unchanged.
- long_done rd=12 with busy[12]=0 -> sb_err=1 and stays 1; assert rst mid-run -> all outputs 0 asynchronously.
